trace_sched: RTL and testbench

- Round-robin scheduler that shares one diagonal-accumulate (trace) datapath between NREQ requesters.
- Each requester offers a packed 2x2 matrix of DW-bit elements.
- The scheduler grants one requester, streams its four elements through the accumulator, and returns the trace tagged with the requester ID.
- Sits in the SOML decoder between the per-branch matrix producers and the metric stage.

---
 rtl/trace_sched_pkg.sv | 18 +
 rtl/trace_diag_acc.sv | 60 ++++++
 rtl/trace_sched.sv | 111 +++++++++++
 tb/tb_trace_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_sched_pkg.sv
// Shared types and constants for the trace scheduler (state encoding, element indices).
// Optional build macro used by this block: TRACE_SAT_EN (signed saturating accumulation).
package trace_sched_pkg;

   localparam int DEF_DW = 16;

   localparam logic [1:0] EL_A00 = 2'd0;
   localparam logic [1:0] EL_A01 = 2'd1;
   localparam logic [1:0] EL_A10 = 2'd2;
   localparam logic [1:0] EL_A11 = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/trace_diag_acc.sv
// Diagonal-select accumulator: adds only a00 and a11 of a streamed 2x2 matrix.
// With TRACE_SAT_EN the sum is signed and saturating, and a sticky sat flag is kept.
module trace_diag_acc
   import trace_sched_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en_elem,
   input  logic [1:0]    elem_idx,
   input  logic [DW-1:0] elem,
   output logic [DW-1:0] acc
`ifdef TRACE_SAT_EN
   ,
   output logic          sat
`endif
);

   logic          diag;
   logic [DW-1:0] sum;
   logic [DW-1:0] acc_nxt;
   logic          ovf;

   assign diag = en_elem && (elem_idx == EL_A00 || elem_idx == EL_A11);
   assign sum  = acc + elem;

`ifdef TRACE_SAT_EN
   // Signed overflow: operands share a sign that the sum does not.
   assign ovf     = (acc[DW-1] == elem[DW-1]) && (sum[DW-1] != acc[DW-1]);
   assign acc_nxt = !ovf ? sum :
                    acc[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`else
   assign ovf     = 1'b0;
   assign acc_nxt = sum;
`endif

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= '0;
      end else if (diag) begin
         acc <= acc_nxt;
      end
   end

`ifdef TRACE_SAT_EN
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sat <= 1'b0;
      end else if (diag && ovf) begin
         sat <= 1'b1;
      end
   end
`else
   logic unused_ovf;
   assign unused_ovf = ovf;
`endif

endmodule

// File: rtl/trace_sched.sv
// Round-robin scheduler sharing one trace (a00+a11) datapath between NREQ requesters.
// Build macro TRACE_SAT_EN adds signed saturation and the res_sat output.
module trace_sched
   import trace_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = DEF_DW,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*4*DW-1:0] req_mat,
   output logic [NREQ-1:0]      req_ready,
   output logic                 res_valid,
   output logic [DW-1:0]        res_trace,
   output logic [IDW-1:0]       res_id,
   input  logic                 res_ready,
`ifdef TRACE_SAT_EN
   output logic                 res_sat,
`endif
   output logic                 busy
);

   if (IDW != $clog2(NREQ)) begin : g_bad_idw
      $error("trace_sched: IDW must equal clog2(NREQ)");
   end

   state_t            state, state_nxt;
   logic [IDW-1:0]    rr_ptr, rr_nxt;
   logic [IDW-1:0]    grant;
   logic              found;
   logic              hs;
   logic [1:0]        elem_idx;
   logic [4*DW-1:0]   mat;
   logic [IDW:0]      grant_p1;

   // First valid requester at or above rr_ptr, wrapping modulo NREQ.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      grant = '0;
      for (int off = 0; off < NREQ; off++) begin
         idx = int'(rr_ptr) + off;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            grant = IDW'(idx);
         end
      end
   end

   assign hs       = (state == IDLE) && found && !rst;
   assign grant_p1 = {1'b0, grant} + 1'b1;
   assign rr_nxt   = (grant_p1 == (IDW+1)'(NREQ)) ? '0 : grant_p1[IDW-1:0];

   always_comb begin
      req_ready = '0;
      if (hs) req_ready[grant] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs) state_nxt = STREAM;
         STREAM:  if (elem_idx == EL_A11) state_nxt = DONE;
         DONE:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         res_id   <= '0;
         elem_idx <= '0;
         mat      <= '0;
      end else begin
         state <= state_nxt;
         if (hs) begin
            mat      <= req_mat[grant*4*DW +: 4*DW];
            res_id   <= grant;
            rr_ptr   <= rr_nxt;
            elem_idx <= EL_A00;
         end else if (state == STREAM) begin
            elem_idx <= elem_idx + 2'd1;
         end
      end
   end

   // The accumulator holds the finished trace through DONE, so it drives res_trace directly.
   trace_diag_acc #(.DW(DW)) u_acc (
      .clk      (clk),
      .rst      (rst),
      .clr      (hs),
      .en_elem  (state == STREAM),
      .elem_idx (elem_idx),
      .elem     (mat[elem_idx*DW +: DW]),
      .acc      (res_trace)
`ifdef TRACE_SAT_EN
      ,
      .sat      (res_sat)
`endif
   );

   assign res_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_trace_sched.sv
// Randomized and directed check of trace_sched against a transaction-level model.
// Honors TRACE_SAT_EN the same way the design does.
module tb_trace_sched;

   localparam int NREQ = 4;
   localparam int DW   = 16;
   localparam int IDW  = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ*4*DW-1:0] req_mat = '0;
   logic [NREQ-1:0]      req_ready;
   logic                 res_valid;
   logic [DW-1:0]        res_trace;
   logic [IDW-1:0]       res_id;
   logic                 res_ready = 1'b0;
   logic                 busy;
`ifdef TRACE_SAT_EN
   logic                 res_sat;
`endif

   trace_sched #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_mat   (req_mat),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_trace (res_trace),
      .res_id    (res_id),
      .res_ready (res_ready),
`ifdef TRACE_SAT_EN
      .res_sat   (res_sat),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: ph 0 = waiting for a grant, 1..4 = streaming cycles, 5 = result offered.
   int          ph = 0;
   int          ptr = 0;
   int          m_id = 0;
   logic [15:0] m_trace = '0;
   logic        m_sat = 1'b0;
   int          cyc = 0;
   int          g_id[$];
   int          g_cyc[$];
   logic [15:0] obs_trace;
   logic [1:0]  obs_id;
   logic        obs_sat;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] mk(input logic [15:0] a00, a01, a10, a11);
      return {a11, a10, a01, a00};
   endfunction

   function automatic logic [255:0] place(input int i, input logic [63:0] x);
      logic [255:0] r;
      r = '0;
      r[i*64 +: 64] = x;
      return r;
   endfunction

   // Returns {saturated, trace} for 0 + a00 + a11.
   function automatic logic [16:0] ref_trace(input logic [15:0] a00, input logic [15:0] a11);
`ifdef TRACE_SAT_EN
      int sa, sb, s;
      sa = int'($signed(a00));
      sb = int'($signed(a11));
      s  = sa + sb;
      if (s > 32767)  return {1'b1, 16'h7FFF};
      if (s < -32768) return {1'b1, 16'h8000};
      return {1'b0, s[15:0]};
`else
      return {1'b0, a00 + a11};
`endif
   endfunction

   task automatic step(input logic [3:0] v, input logic [255:0] m, input logic rr, input logic r);
      int g;
      logic [3:0]  exp_rdy;
      logic [16:0] t;
      @(negedge clk);
      req_valid = v;
      req_mat   = m;
      res_ready = rr;
      rst       = r;
      #1;
      g = -1;
      if (ph == 0 && !r) begin
         for (int off = 0; off < NREQ; off++) begin
            if (g < 0 && v[(ptr + off) % NREQ]) g = (ptr + off) % NREQ;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(ph != 0));
      chk("res_valid", 32'(res_valid), 32'(ph == 5));
      if (ph == 5) begin
         chk("res_trace", 32'(res_trace), 32'(m_trace));
         chk("res_id", 32'(res_id), 32'(m_id));
`ifdef TRACE_SAT_EN
         chk("res_sat", 32'(res_sat), 32'(m_sat));
`endif
      end
      if (res_valid) begin
         obs_trace = res_trace;
         obs_id    = res_id;
`ifdef TRACE_SAT_EN
         obs_sat   = res_sat;
`else
         obs_sat   = 1'b0;
`endif
      end
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            g_id.push_back(i);
            g_cyc.push_back(cyc);
         end
      end
      if (r) begin
         ph  = 0;
         ptr = 0;
      end else if (ph == 0) begin
         if (g >= 0) begin
            t       = ref_trace(m[g*64 +: 16], m[g*64+48 +: 16]);
            m_trace = t[15:0];
            m_sat   = t[16];
            m_id    = g;
            ptr     = (g + 1) % NREQ;
            ph      = 1;
         end
      end else if (ph < 5) begin
         ph++;
      end else if (rr) begin
         ph = 0;
      end
      cyc++;
   endtask

   task automatic clr_obs();
      obs_trace = 16'hDEAD;
      obs_id    = 2'd0;
      obs_sat   = 1'b0;
      g_id.delete();
      g_cyc.delete();
   endtask

   initial begin
      logic [255:0] all;
      logic [63:0]  x;
      clr_obs();
      step(4'b0000, '0, 1'b0, 1'b1);
      step(4'b0000, '0, 1'b0, 1'b1);
      step(4'b0000, '0, 1'b0, 1'b0);
      chk("rst_trace", 32'(res_trace), 32'h0);
      chk("rst_id", 32'(res_id), 32'h0);
      chk("rst_valid", 32'(res_valid), 32'h0);

      // Single request from requester 0.
      clr_obs();
      step(4'b0001, place(0, mk(16'h0003, 16'h1111, 16'h2222, 16'h0004)), 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(4'b0000, '0, 1'b1, 1'b0);
      chk("single_trace", 32'(obs_trace), 32'h0007);
      chk("single_id", 32'(obs_id), 32'h0);

      // Round-robin with all requesters continuously valid.
      step(4'b0000, '0, 1'b0, 1'b1);
      clr_obs();
      all = '0;
      for (int i = 0; i < NREQ; i++) all |= place(i, mk(16'(i+1), 16'h5555, 16'hAAAA, 16'(10*i)));
      for (int i = 0; i < 26; i++) step(4'b1111, all, 1'b1, 1'b0);
      if (g_id.size() < 5) begin
         chk("rr_count", 32'(g_id.size()), 32'd5);
      end else begin
         for (int i = 0; i < 5; i++) chk("rr_order", 32'(g_id[i]), 32'(i % NREQ));
         for (int i = 1; i < 5; i++) chk("rr_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd6);
      end

      // Backpressure: result held for 10 cycles with other requesters waiting.
      while (ph != 5) step(4'b1111, all, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(4'b1111, all, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(4'b1111, all, 1'b1, 1'b0);

      // Overflow of a00 + a11.
      step(4'b0000, '0, 1'b0, 1'b1);
      clr_obs();
      step(4'b0001, place(0, mk(16'h7FFF, 16'h0000, 16'h0000, 16'h0001)), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(4'b0000, '0, 1'b0, 1'b0);
`ifdef TRACE_SAT_EN
      chk("wrap_trace", 32'(obs_trace), 32'h7FFF);
      chk("wrap_sat", 32'(obs_sat), 32'h1);
`else
      chk("wrap_trace", 32'(obs_trace), 32'h8000);
`endif
      step(4'b0000, '0, 1'b1, 1'b0);

      // Reset while streaming element 2, then requester 2 served from rr_ptr=0.
      step(4'b0010, place(1, mk(16'h1, 16'h2, 16'h3, 16'h4)), 1'b1, 1'b0);
      step(4'b0000, '0, 1'b1, 1'b0);
      step(4'b0000, '0, 1'b1, 1'b0);
      step(4'b0000, '0, 1'b1, 1'b1);
      clr_obs();
      x = mk(16'h0100, 16'hFFFF, 16'hFFFF, 16'h0023);
      for (int i = 0; i < 8; i++) step(4'b1100, place(2, x) | place(3, mk(16'h9, 16'h9, 16'h9, 16'h9)), 1'b1, 1'b0);
      chk("rst_mid_id", 32'(obs_id), 32'h2);
      chk("rst_mid_trace", 32'(obs_trace), 32'h0123);

      // Requester 1 valid only in requester 0's grant cycle; requester 3 goes next.
      step(4'b0000, '0, 1'b0, 1'b1);
      clr_obs();
      step(4'b1011, place(0, mk(16'h1, 16'h0, 16'h0, 16'h1)) | place(3, mk(16'h5, 16'h0, 16'h0, 16'h6)), 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) step(4'b1000, place(3, mk(16'h5, 16'h0, 16'h0, 16'h6)), 1'b1, 1'b0);
      chk("skip_cnt", 32'(g_id.size() >= 2), 32'h1);
      if (g_id.size() >= 2) begin
         chk("skip_first", 32'(g_id[0]), 32'h0);
         chk("skip_next", 32'(g_id[1]), 32'h3);
      end

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         logic [255:0] m;
         logic [15:0]  e;
         m = '0;
         for (int k = 0; k < NREQ * 4; k++) begin
            e = 16'($urandom);
            if ($urandom_range(3) == 0) e = 16'h7FF0 + 16'($urandom_range(31));
            m[k*16 +: 16] = e;
         end
         step(4'($urandom), m, ($urandom_range(2) != 0), ($urandom_range(199) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
